// File: rtl/up_sampler_pkg.sv
// Shared constants and FSM state type for the blur-stage up-sampler.
// The Gaussian wrapper pulls its row geometry and pad value from here as well.
package up_sampler_pkg;

    localparam int unsigned RowWDefault = 400;
    localparam int unsigned RowsDefault = 300;
    localparam logic [7:0]  PadByte     = 8'hFF;

    typedef enum logic [1:0] {
        StFill,
        StEmit0,
        StEmit1
    } state_e;

endpackage

// File: rtl/up_sampler_if.sv
// Stream bundle for the up-sampler: upstream FIFO read port plus downstream valid/ready output.
// The slave modport is the up-sampler's view; master is the surrounding pipeline's view.
interface up_sampler_if;

    logic       empty;
    logic       rd_en_up;
    logic       valid;
    logic [7:0] din;
    logic [7:0] dout;
    logic       valid_out;
    logic       ready;

    modport slave (
        input  empty,
        input  valid,
        input  din,
        input  ready,
        output rd_en_up,
        output dout,
        output valid_out
    );

    modport master (
        output empty,
        output valid,
        output din,
        output ready,
        input  rd_en_up,
        input  dout,
        input  valid_out
    );

endinterface

// File: rtl/line_buffer_ram.sv
// Single-row line buffer: one write port, one synchronous read port with read enable.
// The read data register holds its value while re_i is low so a stalled output stage keeps its beat.
module line_buffer_ram #(
    parameter int unsigned Depth = 400,
    parameter int unsigned AddrW = 9
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [7:0]       wdata_i,
    input  logic             re_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [7:0]       rdata_o
);

    logic [7:0] mem_q [Depth];
    logic [7:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/up_sampler.sv
// 2x up-sampler: buffers one padded input row, then streams it twice with every pixel doubled.
// FSM, counters and the registered output stage live here; storage is in line_buffer_ram.
module up_sampler
    import up_sampler_pkg::*;
#(
    parameter int unsigned ROW_W = RowWDefault,
    parameter int unsigned ROWS  = RowsDefault
) (
    input  logic        clk,
    input  logic        rst,
    up_sampler_if.slave bus,
    output logic        frame_end,
    output logic        pad_err
);

    localparam int unsigned CW = $clog2(2 * ROW_W + 1);
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned AW = (ROW_W > 1) ? $clog2(ROW_W) : 1;

    localparam logic [CW-1:0] PadCol   = CW'(ROW_W);
    localparam logic [CW-1:0] BeatLast = CW'(2 * ROW_W - 1);
    localparam logic [CW-1:0] BeatEnd  = CW'(2 * ROW_W);
    localparam logic [RW-1:0] RowLast  = RW'(ROWS - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] issued_q, issued_d;
    logic [CW-1:0] rd_idx_q, rd_idx_d;
    logic          rd_pass_q, rd_pass_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [RW-1:0] row_q, row_d;
    logic          s1_valid_q, s1_valid_d;
    logic          valid_out_q, valid_out_d;
    logic [7:0]    dout_q, dout_d;
    logic          frame_end_q, frame_end_d;
    logic          pad_err_q, pad_err_d;
    logic          rst_dly_q;

    logic          rd_en;
    logic          ram_we;
    logic          ram_re;
    logic [7:0]    ram_rdata;
    logic          advance;
    logic          handshake;

    assign advance   = !valid_out_q || bus.ready;
    assign handshake = valid_out_q && bus.ready;

    line_buffer_ram #(
        .Depth (ROW_W),
        .AddrW (AW)
    ) u_line_buffer_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (AW'(col_q)),
        .wdata_i (bus.din),
        .re_i    (ram_re),
        .raddr_i (AW'(rd_idx_q >> 1)),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        issued_d    = issued_q;
        rd_idx_d    = rd_idx_q;
        rd_pass_d   = rd_pass_q;
        out_cnt_d   = out_cnt_q;
        row_d       = row_q;
        s1_valid_d  = s1_valid_q;
        valid_out_d = valid_out_q;
        dout_d      = dout_q;
        frame_end_d = 1'b0;
        pad_err_d   = pad_err_q;
        rd_en       = 1'b0;
        ram_we      = 1'b0;
        ram_re      = 1'b0;

        // Read side runs ahead of the output stage, wrapping into the second pass so that
        // EMIT1 follows EMIT0 without a bubble.
        if (state_q != StFill && advance) begin
            ram_re      = (rd_idx_q != BeatEnd);
            s1_valid_d  = ram_re;
            valid_out_d = s1_valid_q;
            if (s1_valid_q) begin
                dout_d = ram_rdata;
            end
            if (ram_re) begin
                if (rd_idx_q == BeatLast && !rd_pass_q) begin
                    rd_idx_d  = '0;
                    rd_pass_d = 1'b1;
                end else begin
                    rd_idx_d = rd_idx_q + CW'(1);
                end
            end
        end

        unique case (state_q)
            StFill: begin
                // No read in the first cycle out of reset.
                rd_en = !bus.empty && (issued_q <= PadCol) && !rst_dly_q;
                if (rd_en) begin
                    issued_d = issued_q + CW'(1);
                end
                if (bus.valid) begin
                    if (col_q == PadCol) begin
                        if (bus.din != PadByte) begin
                            pad_err_d = 1'b1;
                        end
                        col_d    = '0;
                        issued_d = '0;
                        state_d  = StEmit0;
                    end else begin
                        ram_we = 1'b1;
                        col_d  = col_q + CW'(1);
                    end
                end
            end
            StEmit0: begin
                if (handshake) begin
                    if (out_cnt_q == BeatLast) begin
                        out_cnt_d = '0;
                        state_d   = StEmit1;
                    end else begin
                        out_cnt_d = out_cnt_q + CW'(1);
                    end
                end
            end
            StEmit1: begin
                if (handshake) begin
                    if (out_cnt_q == BeatLast) begin
                        out_cnt_d = '0;
                        rd_idx_d  = '0;
                        rd_pass_d = 1'b0;
                        state_d   = StFill;
                        if (row_q == RowLast) begin
                            row_d       = '0;
                            frame_end_d = 1'b1;
                        end else begin
                            row_d = row_q + RW'(1);
                        end
                    end else begin
                        out_cnt_d = out_cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk) begin
        rst_dly_q <= rst;
        if (rst) begin
            state_q     <= StFill;
            col_q       <= '0;
            issued_q    <= '0;
            rd_idx_q    <= '0;
            rd_pass_q   <= 1'b0;
            out_cnt_q   <= '0;
            row_q       <= '0;
            s1_valid_q  <= 1'b0;
            valid_out_q <= 1'b0;
            dout_q      <= '0;
            frame_end_q <= 1'b0;
            pad_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            issued_q    <= issued_d;
            rd_idx_q    <= rd_idx_d;
            rd_pass_q   <= rd_pass_d;
            out_cnt_q   <= out_cnt_d;
            row_q       <= row_d;
            s1_valid_q  <= s1_valid_d;
            valid_out_q <= valid_out_d;
            dout_q      <= dout_d;
            frame_end_q <= frame_end_d;
            pad_err_q   <= pad_err_d;
        end
    end

    assign bus.rd_en_up  = rd_en;
    assign bus.dout      = dout_q;
    assign bus.valid_out = valid_out_q;
    assign frame_end     = frame_end_q;
    assign pad_err       = pad_err_q;

endmodule
